// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, PC/IR registers and MEM timeout.
// Optional JAL support is enabled by defining MULTICYCLE_JAL_EN.
module multicycle_ctrl #(
  parameter logic [31:0] INIT_PC     = 32'd0,
  parameter int          MEM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        cmp_eq,
  input  logic        cmp_lt,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [2:0]  alu_op,
  output logic        alu_src_b,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic [4:0]  reg_dst,
  output logic [2:0]  wb_sel,
  output logic [2:0]  state,
  output logic        mem_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam int            CW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        cur, nxt;
  logic [CW-1:0] mem_cnt;
  logic [5:0]    opc;
  logic          op_r, op_i, op_li, op_lui, op_ld, op_st, op_br, op_j, op_jal, op_valid;
  logic          br_taken, mem_last;
  logic [31:0]   jmp_tgt, br_tgt;

  assign opc      = ir[31:26];
  assign op_r     = (opc[5:3] == 3'b010);
  assign op_i     = (opc[5:3] == 3'b110);
  assign op_li    = (opc == 6'b111001);
  assign op_lui   = (opc == 6'b111010);
  assign op_ld    = (opc == 6'b111011) || (opc == 6'b111101);
  assign op_st    = (opc == 6'b111100) || (opc == 6'b111110);
  assign op_br    = (opc[5:2] == 4'b1000);
  assign op_j     = (opc == 6'b000001);
`ifdef MULTICYCLE_JAL_EN
  assign op_jal   = (opc == 6'b000011);
`else
  assign op_jal   = 1'b0;
`endif
  assign op_valid = op_r | op_i | op_li | op_lui | op_ld | op_st | op_br | op_j | op_jal;

  always_comb begin
    br_taken = 1'b0;
    case (opc[1:0])
      2'b00:   br_taken = cmp_eq;
      2'b01:   br_taken = !cmp_eq;
      2'b10:   br_taken = cmp_lt;
      default: br_taken = cmp_lt | cmp_eq;
    endcase
  end

  assign jmp_tgt  = {6'b0, ir[25:0]};
  assign br_tgt   = pc + {{16{ir[15]}}, ir[15:0]};
  assign mem_last = (mem_cnt == CNT_LAST);
  assign state    = cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  // The datapath forms the I-form address with base 0 and the register forms
  // with R[ir[20:16]]; this block only selects add-with-immediate.
  always_comb begin
    nxt       = cur;
    alu_op    = 3'b000;
    alu_src_b = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    reg_dst   = ir[25:21];
    wb_sel    = 3'd0;
    case (cur)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: nxt = op_valid ? S_EXEC : S_FETCH;
      S_EXEC: begin
        if (op_r) begin
          alu_op = ir[28:26];
          nxt    = S_WB;
        end else if (op_i) begin
          alu_op    = ir[28:26];
          alu_src_b = 1'b1;
          nxt       = S_WB;
        end else if (op_li || op_lui || op_jal) begin
          nxt = S_WB;
        end else if (op_ld || op_st) begin
          alu_op    = 3'b010;
          alu_src_b = 1'b1;
          nxt       = S_MEM;
        end else begin
          nxt = S_FETCH;
        end
      end
      S_MEM: begin
        mem_read  = op_ld;
        mem_write = op_st;
        if (mem_ready)     nxt = op_ld ? S_WB : S_FETCH;
        else if (mem_last) nxt = S_FETCH;
      end
      S_WB: begin
        reg_write = 1'b1;
        nxt       = S_FETCH;
        if (op_ld)       wb_sel = 3'd1;
        else if (op_li)  wb_sel = 3'd2;
        else if (op_lui) wb_sel = 3'd3;
`ifdef MULTICYCLE_JAL_EN
        if (op_jal) begin
          wb_sel  = 3'd4;
          reg_dst = 5'd31;
        end
`endif
      end
      default: nxt = S_FETCH;
    endcase
  end

  // JAL commits its jump on the WB edge so pc still carries the link value
  // (post-increment pc) while R31 is written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= INIT_PC;
      ir      <= 32'd0;
      mem_cnt <= '0;
      mem_err <= 1'b0;
    end else begin
      case (cur)
        S_FETCH: begin
          ir <= instr;
          pc <= pc + 32'd1;
        end
        S_EXEC: begin
          if (op_j)                  pc <= jmp_tgt;
          else if (op_br && br_taken) pc <= br_tgt;
        end
        S_WB: begin
          if (op_jal) pc <= jmp_tgt;
        end
        default: ;
      endcase
      if (cur == S_MEM) mem_cnt <= mem_cnt + 1'b1;
      else              mem_cnt <= '0;
      if (cur == S_MEM && !mem_ready && mem_last) mem_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction cycle counts, PC flow,
// write-back pulses, MEM strobes/timeout and asynchronous reset.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        cmp_eq, cmp_lt, mem_ready;
  logic [31:0] pc, ir;
  logic [2:0]  alu_op;
  logic        alu_src_b, mem_read, mem_write, reg_write;
  logic [4:0]  reg_dst;
  logic [2:0]  wb_sel, state;
  logic        mem_err;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
    .mem_ready(mem_ready), .pc(pc), .ir(ir), .alu_op(alu_op), .alu_src_b(alu_src_b),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .wb_sel(wb_sel), .state(state), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];  // expected {wb_sel, reg_dst} per write-back, in order

  int          r_cycles, r_wr, r_mrd, r_mwr, r_excl;
  logic [2:0]  r_alu_op;
  logic        r_src_b;
  logic [31:0] r_wr_pc;
  logic [31:0] exp_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from FETCH until the FSM is back in FETCH (bounded).
  task automatic run(input string tag, input logic [31:0] word, input int ready_delay);
    int mcyc;
    logic [7:0] e;
    mcyc = 0;
    r_cycles = 0; r_wr = 0; r_mrd = 0; r_mwr = 0; r_excl = 0;
    r_alu_op = 3'bx; r_src_b = 1'bx; r_wr_pc = 32'hx;
    instr = word;
    check({tag, ":start"}, {29'd0, state}, 32'd0);
    do begin
      if (state == 3'd3) begin
        mem_ready = (mcyc >= ready_delay);
        mcyc++;
      end else begin
        mem_ready = 1'b0;
      end
      #1;
      if (mem_read) r_mrd++;
      if (mem_write) r_mwr++;
      if (int'(mem_read) + int'(mem_write) + int'(reg_write) > 1) r_excl++;
      if (state == 3'd2) begin
        r_alu_op = alu_op;
        r_src_b  = alu_src_b;
      end
      if (reg_write) begin
        r_wr++;
        r_wr_pc = pc;
        check({tag, ":wb_q"}, exp_q.size(), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check({tag, ":wb"}, {24'd0, wb_sel, reg_dst}, {24'd0, e});
        end
      end
      @(posedge clk);
      #1;
      r_cycles++;
    end while (state != 3'd0 && r_cycles < 40);
    mem_ready = 1'b0;
  endtask

  task automatic basic(input string tag, input int cyc, input logic [31:0] pc_exp, input int nwr);
    check({tag, ":cycles"}, r_cycles, cyc);
    check({tag, ":pc"}, pc, pc_exp);
    check({tag, ":nwr"}, r_wr, nwr);
    check({tag, ":excl"}, r_excl, 0);
  endtask

  initial begin
    reset = 1'b1; instr = 32'd0; cmp_eq = 1'b0; cmp_lt = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst:state", {29'd0, state}, 32'd0);
    check("rst:pc", pc, 32'd0);
    check("rst:ir", ir, 32'd0);
    check("rst:mem_err", {31'd0, mem_err}, 32'd0);
    check("rst:strobes", {29'd0, mem_read, mem_write, reg_write}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    exp_q.push_back({3'd2, 5'd0});
    run("li", 32'hE400FFFF, 0);   basic("li", 4, 32'd1, 1);
    exp_q.push_back({3'd3, 5'd0});
    run("lui", 32'hE800FFFF, 0);  basic("lui", 4, 32'd2, 1);
    exp_q.push_back({3'd0, 5'd3});
    run("add", 32'h44601000, 0);  basic("add", 4, 32'd3, 1);
    check("add:alu_op", {29'd0, r_alu_op}, 32'd1);
    check("add:src_b", {31'd0, r_src_b}, 32'd0);
    exp_q.push_back({3'd0, 5'd4});
    run("addi", 32'hC4800005, 0); basic("addi", 4, 32'd4, 1);
    check("addi:alu_op", {29'd0, r_alu_op}, 32'd1);
    check("addi:src_b", {31'd0, r_src_b}, 32'd1);

    run("j12", 32'h0400000C, 0);  basic("j12", 3, 32'd12, 0);
    cmp_eq = 1'b0;
    run("bne_t", 32'h8400FFFD, 0); basic("bne_t", 3, 32'd10, 0);
    run("nop", 32'h00000000, 0);  basic("nop", 2, 32'd11, 0);
    run("j12b", 32'h0400000C, 0); basic("j12b", 3, 32'd12, 0);
    cmp_eq = 1'b1;
    run("bne_nt", 32'h8400FFFD, 0); basic("bne_nt", 3, 32'd13, 0);
    cmp_eq = 1'b0;
    run("j18", 32'h04000012, 0);  basic("j18", 3, 32'd18, 0);
    run("j21", 32'h04000015, 0);  basic("j21", 3, 32'd21, 0);

    exp_q.push_back({3'd1, 5'd7});
    run("lwi", 32'hECE00040, 3);  basic("lwi", 8, 32'd22, 1);
    check("lwi:mrd", r_mrd, 4);
    check("lwi:mwr", r_mwr, 0);
    check("lwi:alu_op", {29'd0, r_alu_op}, 32'd2);
    check("lwi:src_b", {31'd0, r_src_b}, 32'd1);
    check("lwi:mem_err", {31'd0, mem_err}, 32'd0);

    cmp_eq = 1'b1;
    run("beq_t", 32'h80000002, 0); basic("beq_t", 3, 32'd25, 0);
    cmp_eq = 1'b0; cmp_lt = 1'b1;
    run("ble_t", 32'h8C00FFFE, 0); basic("ble_t", 3, 32'd24, 0);
    cmp_lt = 1'b0;
    run("blt_nt", 32'h88000005, 0); basic("blt_nt", 3, 32'd25, 0);
    run("j5", 32'h04000005, 0);   basic("j5", 3, 32'd5, 0);

`ifdef MULTICYCLE_JAL_EN
    exp_q.push_back({3'd4, 5'd31});
    run("jal", 32'h0C00001E, 0);  basic("jal", 4, 32'd30, 1);
    check("jal:link", r_wr_pc, 32'd6);
    exp_pc = 32'd30;
`else
    run("jal", 32'h0C00001E, 0);  basic("jal", 2, 32'd6, 0);
    exp_pc = 32'd6;
`endif

    run("sw_to", 32'hF8400010, 1000); basic("sw_to", 11, exp_pc + 32'd1, 0);
    check("sw_to:mwr", r_mwr, 8);
    check("sw_to:mrd", r_mrd, 0);
    check("sw_to:mem_err", {31'd0, mem_err}, 32'd1);
    run("swi", 32'hF0000000, 0);  basic("swi", 4, exp_pc + 32'd2, 0);
    check("swi:mwr", r_mwr, 1);
    check("swi:mem_err", {31'd0, mem_err}, 32'd1);
    run("unk", 32'hFC000000, 0);  basic("unk", 2, exp_pc + 32'd3, 0);

    instr = 32'hF4000000;
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mrst:in_mem", {29'd0, state}, 32'd3);
    check("mrst:mrd", {31'd0, mem_read}, 32'd1);
    reset = 1'b1;
    #1;
    check("mrst:state", {29'd0, state}, 32'd0);
    check("mrst:pc", pc, 32'd0);
    check("mrst:ir", ir, 32'd0);
    check("mrst:mem_err", {31'd0, mem_err}, 32'd0);
    check("mrst:strobes", {29'd0, mem_read, mem_write, reg_write}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    instr = 32'd0;
    @(posedge clk);
    #1;
    check("post_rst:state", {29'd0, state}, 32'd1);
    check("post_rst:pc", pc, 32'd1);

    check("exp_q:empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
